// File: rtl/icache_pkg.sv
// icache_pkg: shared geometry, address slicing and state encoding for the instruction cache
package icache_pkg;
  localparam int WAY_COUNT = 2;
  localparam int SET_COUNT = 64;
  localparam int WAY_WORD_COUNT = 4;
  localparam int WAY_W = $clog2(WAY_COUNT);
  localparam int SET_W = $clog2(SET_COUNT);
  localparam int WORD_W = $clog2(WAY_WORD_COUNT);
  localparam int TAG_W = 32 - 2 - WORD_W - SET_W;
  localparam int LINE_W = WAY_WORD_COUNT * 32;
  typedef enum logic [2:0] {IDLE, COMPARE, RESP, REFILL_REQ, REFILL_WAIT, WRITE, FLUSH} state_t;
  typedef struct packed {
    logic found;
    logic [WAY_W-1:0] way;
  } way_sel_t;
  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31 -: TAG_W];
  endfunction
  function automatic logic [SET_W-1:0] addr_set(input logic [31:0] a);
    return a[2+WORD_W +: SET_W];
  endfunction
  function automatic logic [WORD_W-1:0] addr_word(input logic [31:0] a);
    return a[2 +: WORD_W];
  endfunction
  // Lowest-index way whose bit is clear; also serves as a lowest-hit picker on an inverted hit vector.
  function automatic way_sel_t first_invalid(input logic [WAY_COUNT-1:0] v);
    way_sel_t r;
    r = '0;
    for (int i = WAY_COUNT - 1; i >= 0; i--)
      if (!v[i]) r = '{found: 1'b1, way: WAY_W'(i)};
    return r;
  endfunction
endpackage

// File: rtl/icache_refill_buf.sv
// icache_refill_buf: refill line buffer, written one word at a time and read by word index
module icache_refill_buf
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [WORD_W-1:0] widx,
  input  logic [31:0]       wdata,
  input  logic [WORD_W-1:0] ridx,
  output logic [LINE_W-1:0] line,
  output logic [31:0]       rdata
);
  always_ff @(posedge clk or posedge reset)
    if (reset) line <= '0;
    else if (we) line[{widx, 5'd0} +: 32] <= wdata;
  assign rdata = line[{ridx, 5'd0} +: 32];
endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: read-only instruction cache controller with line refill and invalidate-all flush
module icache_ctrl
  import icache_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      core_req_i,
  input  logic [31:0]               core_addr_i,
  output logic                      core_gnt_o,
  output logic                      core_rvalid_o,
  output logic [31:0]               core_rdata_o,
  input  logic                      flush_i,
  output logic                      flush_busy_o,
  output logic                      ext_req_o,
  output logic [31:0]               ext_addr_o,
  input  logic                      ext_gnt_i,
  input  logic                      ext_rvalid_i,
  input  logic [31:0]               ext_rdata_i,
  output logic [SET_W-1:0]          cm_set_o,
  output logic [WAY_W-1:0]          cm_way_o,
  output logic                      cm_enable_o,
  output logic                      cm_we_o,
  output logic                      cm_val_we_o,
  output logic                      cm_line_valid_o,
  output logic [TAG_W-1:0]          cm_line_tag_o,
  output logic [LINE_W-1:0]         cm_line_o,
  output logic [WAY_WORD_COUNT*4-1:0] cm_line_be_o,
  input  logic [WAY_COUNT-1:0]      cm_valid_i,
  input  logic [TAG_W*WAY_COUNT-1:0] cm_tag_i,
  input  logic [LINE_W-1:0]         cm_line_i
);
  state_t state, state_n;
  logic [31:0] addr_q, buf_rdata;
  logic [WAY_W-1:0] victim_q, ptr_q;
  logic [WORD_W-1:0] cnt_q;
  logic [SET_W+WAY_W-1:0] fcnt_q;
  logic flush_pend, buf_we;
  logic [WAY_COUNT-1:0] hit;
  way_sel_t hit_sel, inv_sel;
  for (genvar w = 0; w < WAY_COUNT; w++) begin : g_hit
    assign hit[w] = cm_valid_i[w] && cm_tag_i[w*TAG_W +: TAG_W] == addr_tag(addr_q);
  end
  assign hit_sel = first_invalid(~hit);
  assign inv_sel = first_invalid(cm_valid_i);
  assign flush_busy_o = flush_pend || state == FLUSH;
  icache_refill_buf u_buf (
    .clk   (clk),
    .reset (reset),
    .we    (buf_we),
    .widx  (cnt_q),
    .wdata (ext_rdata_i),
    .ridx  (addr_word(addr_q)),
    .line  (cm_line_o),
    .rdata (buf_rdata)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      addr_q <= '0;
      victim_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      fcnt_q <= '0;
      flush_pend <= 1'b0;
    end else begin
      state <= state_n;
      flush_pend <= flush_i || (flush_pend && state != IDLE);
      fcnt_q <= state == FLUSH ? fcnt_q + 1'b1 : '0;
      if (core_gnt_o) addr_q <= core_addr_i;
      if (state == COMPARE && !hit_sel.found) begin
        victim_q <= inv_sel.found ? inv_sel.way : ptr_q;
        ptr_q <= ptr_q + 1'b1;
        cnt_q <= '0;
      end
      if (buf_we && cnt_q != WORD_W'(WAY_WORD_COUNT - 1)) cnt_q <= cnt_q + 1'b1;
      if (state == FLUSH) ptr_q <= '0;
    end
  always_comb begin
    state_n = state;
    core_gnt_o = 1'b0;
    core_rvalid_o = 1'b0;
    core_rdata_o = '0;
    ext_req_o = 1'b0;
    ext_addr_o = '0;
    cm_set_o = addr_set(addr_q);
    cm_way_o = '0;
    cm_enable_o = 1'b0;
    cm_we_o = 1'b0;
    cm_val_we_o = 1'b0;
    cm_line_valid_o = 1'b0;
    cm_line_tag_o = '0;
    cm_line_be_o = '0;
    buf_we = 1'b0;
    case (state)
      IDLE:
        if (flush_pend) state_n = FLUSH;
        else if (core_req_i) begin
          core_gnt_o = 1'b1;
          cm_enable_o = 1'b1;
          cm_set_o = addr_set(core_addr_i);
          state_n = COMPARE;
        end
      COMPARE: begin
        cm_enable_o = hit_sel.found;
        cm_way_o = hit_sel.way;
        state_n = hit_sel.found ? RESP : REFILL_REQ;
      end
      RESP: begin
        core_rvalid_o = 1'b1;
        core_rdata_o = cm_line_i[{addr_word(addr_q), 5'd0} +: 32];
        state_n = IDLE;
      end
      REFILL_REQ: begin
        ext_req_o = 1'b1;
        ext_addr_o = {addr_q[31:2+WORD_W], cnt_q, 2'b00};
        state_n = ext_gnt_i ? REFILL_WAIT : REFILL_REQ;
      end
      REFILL_WAIT: begin
        buf_we = ext_rvalid_i;
        if (ext_rvalid_i) state_n = cnt_q == WORD_W'(WAY_WORD_COUNT - 1) ? WRITE : REFILL_REQ;
      end
      WRITE: begin
        cm_enable_o = 1'b1;
        cm_we_o = 1'b1;
        cm_way_o = victim_q;
        cm_line_valid_o = 1'b1;
        cm_line_tag_o = addr_tag(addr_q);
        cm_line_be_o = '1;
        core_rvalid_o = 1'b1;
        core_rdata_o = buf_rdata;
        state_n = IDLE;
      end
      FLUSH: begin
        cm_enable_o = 1'b1;
        cm_val_we_o = 1'b1;
        cm_set_o = fcnt_q[WAY_W +: SET_W];
        cm_way_o = fcnt_q[WAY_W-1:0];
        state_n = &fcnt_q ? IDLE : FLUSH;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed bench with storage and external memory models around icache_ctrl
module tb_icache_ctrl;
  import icache_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic core_req_i = 1'b0, flush_i = 1'b0;
  logic [31:0] core_addr_i = '0;
  logic core_gnt_o, core_rvalid_o, flush_busy_o, ext_req_o;
  logic [31:0] core_rdata_o, ext_addr_o;
  logic ext_gnt_i = 1'b0, ext_rvalid_i = 1'b0;
  logic [31:0] ext_rdata_i = '0;
  logic [SET_W-1:0] cm_set_o;
  logic [WAY_W-1:0] cm_way_o;
  logic cm_enable_o, cm_we_o, cm_val_we_o, cm_line_valid_o;
  logic [TAG_W-1:0] cm_line_tag_o;
  logic [LINE_W-1:0] cm_line_o, cm_line_i;
  logic [WAY_WORD_COUNT*4-1:0] cm_line_be_o;
  logic [WAY_COUNT-1:0] cm_valid_i;
  logic [TAG_W*WAY_COUNT-1:0] cm_tag_i;
  logic [WAY_COUNT-1:0] val_m [SET_COUNT];
  logic [WAY_COUNT-1:0][TAG_W-1:0] tag_m [SET_COUNT];
  logic [LINE_W-1:0] line_m [SET_COUNT][WAY_COUNT];
  logic [31:0] ext_log [$];
  int gnt_dly = 0, rv_dly = 0;
  int checks = 0, failures = 0;
  int wr_cnt = 0, vw_cnt = 0, rv_cnt = 0, stab_err = 0;
  logic [WAY_W-1:0] wr_way = '1;
  logic [TAG_W-1:0] wr_tag = '1;
  logic [LINE_W-1:0] wr_line = '0;
  logic p_req = 1'b0;
  logic [31:0] p_addr = '0;
  logic [31:0] d;
  int lat, n, wr0, vw0, rv0;
  logic busy_seen;

  icache_ctrl dut (
    .clk(clk), .reset(reset),
    .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_gnt_o(core_gnt_o),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .flush_i(flush_i), .flush_busy_o(flush_busy_o),
    .ext_req_o(ext_req_o), .ext_addr_o(ext_addr_o), .ext_gnt_i(ext_gnt_i),
    .ext_rvalid_i(ext_rvalid_i), .ext_rdata_i(ext_rdata_i),
    .cm_set_o(cm_set_o), .cm_way_o(cm_way_o), .cm_enable_o(cm_enable_o), .cm_we_o(cm_we_o),
    .cm_val_we_o(cm_val_we_o), .cm_line_valid_o(cm_line_valid_o), .cm_line_tag_o(cm_line_tag_o),
    .cm_line_o(cm_line_o), .cm_line_be_o(cm_line_be_o),
    .cm_valid_i(cm_valid_i), .cm_tag_i(cm_tag_i), .cm_line_i(cm_line_i)
  );

  always #5 clk = ~clk;

  // Storage wrapper model: combinational validity, one-cycle tag/line read.
  assign cm_valid_i = val_m[cm_set_o];
  always @(posedge clk or posedge reset)
    if (reset) begin
      for (int s = 0; s < SET_COUNT; s++) val_m[s] <= '0;
    end else if (cm_enable_o) begin
      if (cm_we_o) begin
        tag_m[cm_set_o][cm_way_o] <= cm_line_tag_o;
        line_m[cm_set_o][cm_way_o] <= cm_line_o;
      end
      if (cm_we_o || cm_val_we_o) val_m[cm_set_o][cm_way_o] <= cm_line_valid_o;
      cm_tag_i <= tag_m[cm_set_o];
      cm_line_i <= line_m[cm_set_o][cm_way_o];
    end

  always @(posedge clk) begin
    if (cm_enable_o && cm_we_o) begin
      wr_cnt <= wr_cnt + 1;
      wr_way <= cm_way_o;
      wr_tag <= cm_line_tag_o;
      wr_line <= cm_line_o;
    end
    if (cm_enable_o && cm_val_we_o) vw_cnt <= vw_cnt + 1;
    if (core_rvalid_o) rv_cnt <= rv_cnt + 1;
  end

  // Gnt seen at a negedge answers the request seen at the previous negedge.
  always @(negedge clk) begin
    if (p_req && !ext_gnt_i && (!ext_req_o || ext_addr_o != p_addr)) stab_err <= stab_err + 1;
    p_req <= ext_req_o;
    p_addr <= ext_addr_o;
  end

  // External memory: returns the word address as data, with programmable grant/data delays.
  always begin
    logic [31:0] a;
    @(negedge clk); #1;
    if (ext_req_o) begin
      repeat (gnt_dly) begin @(negedge clk); #1; end
      a = ext_addr_o;
      ext_log.push_back(a);
      ext_gnt_i = 1'b1;
      @(negedge clk); #1;
      ext_gnt_i = 1'b0;
      repeat (rv_dly) begin @(negedge clk); #1; end
      ext_rdata_i = a;
      ext_rvalid_i = 1'b1;
      @(negedge clk); #1;
      ext_rvalid_i = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] a, output logic [31:0] dd, output int lt);
    int k;
    core_req_i = 1'b1;
    core_addr_i = a;
    #1;
    k = 0;
    while (!core_gnt_o && k < 2000) begin @(negedge clk); #1; k++; end
    @(negedge clk);
    core_req_i = 1'b0;
    lt = 1;
    while (!core_rvalid_o && lt < 2000) begin @(negedge clk); lt++; end
    dd = core_rdata_o;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_gnt", core_gnt_o, 0);
    chk("rst_rvalid", core_rvalid_o, 0);
    chk("rst_ext_req", ext_req_o, 0);
    chk("rst_ext_addr", ext_addr_o, 0);
    chk("rst_cm_en", cm_enable_o, 0);
    chk("rst_flush_busy", flush_busy_o, 0);
    chk("rst_cm_line", cm_line_o, 0);
    reset = 1'b0;
    @(negedge clk);
    // Cold miss
    wr0 = wr_cnt;
    fetch(32'h404, d, lat);
    chk("cold_data", d, 32'h404);
    chk("cold_ext_n", ext_log.size(), 4);
    chk("cold_ext0", ext_log[0], 32'h400);
    chk("cold_ext1", ext_log[1], 32'h404);
    chk("cold_ext2", ext_log[2], 32'h408);
    chk("cold_ext3", ext_log[3], 32'h40C);
    chk("cold_wr_n", wr_cnt - wr0, 1);
    chk("cold_way", wr_way, 0);
    chk("cold_tag", wr_tag, 22'h1);
    chk("cold_line", wr_line, {32'h40C, 32'h408, 32'h404, 32'h400});
    // Hit after refill
    ext_log.delete();
    fetch(32'h40C, d, lat);
    chk("hit_lat", lat, 2);
    chk("hit_data", d, 32'h40C);
    chk("hit_no_ext", ext_log.size(), 0);
    // Replacement in set 0
    fetch(32'h800, d, lat);
    chk("t2_data", d, 32'h800);
    chk("t2_way", wr_way, 1);
    fetch(32'hC04, d, lat);
    chk("t3_data", d, 32'hC04);
    chk("t3_way", wr_way, 0);
    chk("t3_tag", wr_tag, 22'h3);
    ext_log.delete();
    fetch(32'h808, d, lat);
    chk("t2_hit_lat", lat, 2);
    chk("t2_hit_data", d, 32'h808);
    chk("t2_hit_no_ext", ext_log.size(), 0);
    // External stalls
    gnt_dly = 3;
    rv_dly = 5;
    ext_log.delete();
    rv0 = rv_cnt;
    fetch(32'h828, d, lat);
    chk("stall_data", d, 32'h828);
    chk("stall_ext0", ext_log[0], 32'h820);
    chk("stall_ext3", ext_log[3], 32'h82C);
    chk("stall_line", wr_line, {32'h82C, 32'h828, 32'h824, 32'h820});
    chk("stall_stable", stab_err, 0);
    chk("stall_one_rvalid", rv_cnt - rv0, 1);
    gnt_dly = 0;
    rv_dly = 0;
    // Re-cache 0x404 (evicts way 0 via pointer), confirm hit
    fetch(32'h404, d, lat);
    chk("recache_way", wr_way, 0);
    fetch(32'h404, d, lat);
    chk("recache_hit_lat", lat, 2);
    chk("recache_hit_data", d, 32'h404);
    // Flush during refill
    vw0 = vw_cnt;
    busy_seen = 1'b0;
    fork
      fetch(32'h2010, d, lat);
      begin
        repeat (3) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        busy_seen = flush_busy_o;
      end
    join
    chk("flush_fetch_data", d, 32'h2010);
    chk("flush_busy_seen", busy_seen, 1);
    n = 0;
    while (flush_busy_o && n < 1000) begin @(negedge clk); n++; end
    chk("flush_busy_drop", flush_busy_o, 0);
    chk("flush_val_we_n", vw_cnt - vw0, 128);
    ext_log.delete();
    fetch(32'h404, d, lat);
    chk("post_flush_miss", ext_log.size(), 4);
    chk("post_flush_data", d, 32'h404);
    // Reset while waiting for refill data
    rv_dly = 5;
    ext_log.delete();
    core_req_i = 1'b1;
    core_addr_i = 32'h3030;
    @(negedge clk);
    core_req_i = 1'b0;
    n = 0;
    while (ext_log.size() < 2 && n < 200) begin @(negedge clk); n++; end
    chk("rst_mid_reached", ext_log.size(), 2);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_ext_req", ext_req_o, 0);
    chk("rst_mid_rvalid", core_rvalid_o, 0);
    chk("rst_mid_cm_en", cm_enable_o, 0);
    chk("rst_mid_buf", cm_line_o, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    rv_dly = 0;
    ext_log.delete();
    fetch(32'h3030, d, lat);
    chk("rst_refetch_ext0", ext_log[0], 32'h3030);
    chk("rst_refetch_n", ext_log.size(), 4);
    chk("rst_refetch_data", d, 32'h3030);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Read-only instruction-cache controller in front of the cache storage wrapper (tag/validity/content arrays, 1-cycle SRAM read latency, combinational per-set validity).
- Accepts core fetches over a req/gnt/rvalid interface and detects hits by comparing all way tags of the indexed set.
- On a miss it refills a full line from the external memory port word by word, then writes the line, tag and valid bit into the storage wrapper.
- Also provides a full-cache flush (invalidate-all) sequence.

Parameters:
- WAY_COUNT, 2, ways per set (power of 2, ≥2)
- SET_COUNT, 64, sets (power of 2)
- WAY_WORD_COUNT, 4, 32-bit words per line (power of 2, ≥2)
- Derived (shared package): WORD_IDX [WW+1:2], SET_IDX above it, TAG_IDX up to bit 31; TAG_W=32-2-log2(WAY_WORD_COUNT)-log2(SET_COUNT)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- core_req_i  in  1  fetch request
- core_addr_i  in  32  word-aligned fetch address
- core_gnt_o  out  1  request accepted this cycle
- core_rvalid_o  out  1  core_rdata_o valid (1 cycle pulse)
- core_rdata_o  out  32  fetched word
- flush_i  in  1  invalidate-all request (pulse)
- flush_busy_o  out  1  flush pending or running
- ext_req_o / ext_addr_o[32]  out  external word read request, held until ext_gnt_i
- ext_gnt_i / ext_rvalid_i  in  1  grant / read data valid
- ext_rdata_i  in  32  external read data
- cm_set_o  out  log2(SET_COUNT)  storage set index
- cm_way_o  out  log2(WAY_COUNT)  storage way
- cm_enable_o, cm_we_o, cm_val_we_o  out  1  storage enable / line+tag write / validity-only write
- cm_line_valid_o  out  1  validity bit to write
- cm_line_tag_o  out  TAG_W  tag to write
- cm_line_o  out  WAY_WORD_COUNT*32  line to write
- cm_line_be_o  out  WAY_WORD_COUNT*4  byte enables (all ones on refill)
- cm_valid_i  in  WAY_COUNT  per-way validity of cm_set_o (combinational)
- cm_tag_i  in  TAG_W*WAY_COUNT  per-way tags (1 cycle after enable)
- cm_line_i  in  WAY_WORD_COUNT*32  line of (set,way) (1 cycle after enable)

Behaviour:
- Reset: all outputs 0; FSM=IDLE; victim pointer 0; flush-pending 0; line buffer cleared.
- States: IDLE, COMPARE, RESP, REFILL_REQ, REFILL_WAIT, WRITE, FLUSH.
- IDLE:
  - Flush-pending has priority: go to FLUSH, gnt=0.
  - Else if core_req_i: gnt=1, latch addr, cm_enable=1 with set of addr; go to COMPARE.
- COMPARE:
  - Hold cm_set_o; hit = valid & tag match per way.
  - Hit: cm_enable=1, cm_way=hit way, go to RESP.
  - Miss: victim = lowest invalid way, else victim pointer; pointer increments modulo WAY_COUNT on every refill; go to REFILL_REQ with word counter 0.
  - Multiple matching ways are illegal; lowest index wins.
- RESP: rvalid=1, rdata = cm_line_i word selected by addr[WORD_IDX]; go to IDLE. Hit latency: rvalid exactly 2 cycles after gnt.
- REFILL_REQ: ext_req=1, ext_addr = {tag, set, counter, 2'b00}, starting at word 0 (not critical-word-first). Stay until ext_gnt_i, then go to REFILL_WAIT.
- REFILL_WAIT: on ext_rvalid_i store word at counter. If counter is the last word go to WRITE, else increment counter and go to REFILL_REQ. One outstanding external request at a time.
- WRITE (1 cycle):
  - cm_enable=1, cm_we=1, cm_way=victim, tag, cm_line_valid_o=1, be all ones.
  - Same cycle: rvalid=1, rdata from line buffer at requested word; then IDLE.
- FLUSH:
  - Counter walks set 0..SET_COUNT-1, way 0..WAY_COUNT-1, one entry per cycle with cm_enable=1, cm_val_we=1, valid=0.
  - Takes exactly SET_COUNT*WAY_COUNT cycles; victim pointer reset to 0; then IDLE.
  - flush_busy_o is high from the cycle after flush_i until the last flush write.
- flush_i during any non-IDLE state: latched into flush-pending and served when the FSM returns to IDLE. The in-flight fetch completes first.
- core_gnt_o is asserted only in IDLE. core_req_i may stay high and is re-granted on the next IDLE cycle.
- Reset mid-refill or mid-flush: immediate return to IDLE; ext_req_o drops asynchronously; partial line discarded. The storage wrapper's own reset clears validity.
- Widths: ext_addr_o low 2 bits are always 0. The word counter wraps only via the state exit, never arithmetically.

Decomposition:
- Package icache_pkg:
  - Derived index widths/ranges and the state enum.
  - Functions addr_tag/addr_set/addr_word.
  - Function first_invalid(valid vector) returning way and found flag.
- One sub-module: icache_refill_buf, the line buffer with word-write by index and word-select read (128-bit at defaults).
- All other logic lives in icache_ctrl.

Test Plan:
- Cold miss: fetch 0x0000_0404 (set 0, word 1) with ext memory returning addr-as-data, no stall.
  - Required: ext reads 0x400, 0x404, 0x408, 0x40C.
  - Required: WRITE way 0 with tag 0x000001.
  - Required: rdata 0x404.
- Hit after refill: fetch 0x0000_040C.
  - Required: rvalid 2 cycles after gnt, rdata 0x40C, no ext_req.
- Replacement: fill set 0 with tags 1 and 2, then miss tag 3.
  - Required: victim way 0 (pointer 0→1 after two refills wraps to 0).
  - Required: tag-2 line still hits afterwards.
- Ext stalls: ext_gnt delayed 3 cycles, ext_rvalid 5 cycles per word.
  - Required: ext_req_o/ext_addr_o stable until grant.
  - Required: correct line and single rvalid.
- Flush during refill: pulse flush_i mid-miss.
  - Required: the fetch completes, then 128 val_we cycles.
  - Required: the previously cached 0x404 misses afterwards.
- Reset asserted in REFILL_WAIT: ext_req_o=0 and FSM in IDLE immediately; the next fetch to the same address refills from word 0.
